// File: rtl/pd_pkg.sv
// Shared definitions for the iterative projective point doubler:
// FSM states, multiplication step encoding, default field and modular add/sub.
package pd_pkg;

   localparam int PD_W = 255;
   localparam logic [254:0] PD_P =
      255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

   // Working width of the helpers; callers zero-extend and truncate back to W.
   localparam int MAXW = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef logic [2:0] step_t;

   localparam step_t STEP_B  = 3'd0;
   localparam step_t STEP_C  = 3'd1;
   localparam step_t STEP_D  = 3'd2;
   localparam step_t STEP_H  = 3'd3;
   localparam step_t STEP_X2 = 3'd4;
   localparam step_t STEP_Y2 = 3'd5;
   localparam step_t STEP_Z2 = 3'd6;

   // Operands must already be below p, so one conditional subtraction suffices.
   function automatic logic [MAXW-1:0] mod_add(input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b,
                                               input logic [MAXW-1:0] p);
      logic [MAXW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, p}) begin
         s = s - {1'b0, p};
      end else begin
         s = s;
      end
      return s[MAXW-1:0];
   endfunction

   function automatic logic [MAXW-1:0] mod_sub(input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b,
                                               input logic [MAXW-1:0] p);
      logic [MAXW-1:0] d;
      d = a - b;
      if (a < b) begin
         d = d + p;
      end else begin
         d = d;
      end
      return d;
   endfunction

endpackage

// File: rtl/mod_mul.sv
// Bit-serial MSB-first interleaved modular multiplier: product = a*b mod P.
// done pulses with the product during the cycle the last multiplier bit is consumed.
module mod_mul
   import pd_pkg::*;
#(
   parameter int           W = PD_W,
   parameter logic [W-1:0] P = PD_P[W-1:0]
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] product
);
   localparam int CW = $clog2(W + 1);

   logic          busy;
   logic [CW-1:0] cnt;
   logic [W-1:0]  ra;
   logic [W-1:0]  rb;
   logic [W-1:0]  acc;
   logic [W-1:0]  dbl;
   logic [W-1:0]  acc_next;

   // One Horner step: acc = 2*acc (+ b when the current multiplier bit is set).
   always_comb begin
      dbl = W'(mod_add(MAXW'(acc), MAXW'(acc), MAXW'(P)));
      if (ra[W-1]) begin
         acc_next = W'(mod_add(MAXW'(dbl), MAXW'(rb), MAXW'(P)));
      end else begin
         acc_next = dbl;
      end
      done    = busy && (cnt == CW'(1));
      product = acc_next;
   end

   // Operand load on start, then one multiplier bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= {CW{1'b0}};
         ra   <= {W{1'b0}};
         rb   <= {W{1'b0}};
         acc  <= {W{1'b0}};
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(W);
         ra   <= a;
         rb   <= b;
         acc  <= {W{1'b0}};
      end else if (busy) begin
         acc  <= acc_next;
         ra   <= {ra[W-2:0], 1'b0};
         cnt  <= cnt - CW'(1);
         busy <= (cnt != CW'(1));
      end
   end

endmodule

// File: rtl/point_double_iter.sv
// Projective point doubling on a = -1 / +1 curves using one shared serial
// modular multiplier driven through seven fixed multiplication steps.
module point_double_iter
   import pd_pkg::*;
#(
   parameter int           W     = PD_W,
   parameter logic [W-1:0] P     = PD_P[W-1:0],
   parameter bit           A_NEG = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] y1,
   input  logic [W-1:0] z1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x2,
   output logic [W-1:0] y2,
   output logic [W-1:0] z2
);
   state_t       state;
   state_t       state_next;
   step_t        step;
   logic         accept;
   logic         mul_start;
   logic         mul_done;
   logic [W-1:0] product;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] rx, ry, rz, rb, rc, rd, rh, rx2, ry2, rz2;
   logic [W-1:0] e_v, f_v, j_v;

   function automatic logic [W-1:0] add_p(input logic [W-1:0] a, input logic [W-1:0] b);
      return W'(mod_add(MAXW'(a), MAXW'(b), MAXW'(P)));
   endfunction

   function automatic logic [W-1:0] sub_p(input logic [W-1:0] a, input logic [W-1:0] b);
      return W'(mod_sub(MAXW'(a), MAXW'(b), MAXW'(P)));
   endfunction

   assign accept = in_valid && in_ready;

   mod_mul #(.W(W), .P(P)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (product)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and multiplier launch.
   always_comb begin
      state_next = state;
      mul_start  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_next = ST_MUL;
            else        state_next = ST_IDLE;
         end
         ST_MUL: begin
            mul_start  = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_done) state_next = (step == STEP_Z2) ? ST_DONE : ST_MUL;
            else          state_next = ST_WAIT;
         end
         ST_DONE: begin
            if (out_valid && out_ready) state_next = ST_IDLE;
            else                        state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Derived field values and operand selection for the current step.
   always_comb begin
      if (A_NEG) begin
         if (rc == {W{1'b0}}) e_v = {W{1'b0}};
         else                 e_v = P - rc;
      end else begin
         e_v = rc;
      end
      f_v = add_p(e_v, rd);
      j_v = sub_p(f_v, add_p(rh, rh));
      case (step)
         STEP_B:  begin op_a = add_p(rx, ry);             op_b = add_p(rx, ry);     end
         STEP_C:  begin op_a = rx;                        op_b = rx;                end
         STEP_D:  begin op_a = ry;                        op_b = ry;                end
         STEP_H:  begin op_a = rz;                        op_b = rz;                end
         STEP_X2: begin op_a = sub_p(sub_p(rb, rc), rd);  op_b = j_v;               end
         STEP_Y2: begin op_a = f_v;                       op_b = sub_p(e_v, rd);    end
         STEP_Z2: begin op_a = f_v;                       op_b = j_v;               end
         default: begin op_a = {W{1'b0}};                 op_b = {W{1'b0}};         end
      endcase
   end

   // Input capture, per-step product storage and result presentation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         step      <= STEP_B;
         {rx, ry, rz, rb, rc, rd, rh, rx2, ry2, rz2} <= {(10*W){1'b0}};
         {x2, y2, z2} <= {(3*W){1'b0}};
      end else begin
         in_ready <= (state_next == ST_IDLE);
         if (accept) begin
            rx   <= x1;
            ry   <= y1;
            rz   <= z1;
            step <= STEP_B;
         end else if ((state == ST_WAIT) && mul_done) begin
            case (step)
               STEP_B:  rb  <= product;
               STEP_C:  rc  <= product;
               STEP_D:  rd  <= product;
               STEP_H:  rh  <= product;
               STEP_X2: rx2 <= product;
               STEP_Y2: ry2 <= product;
               STEP_Z2: rz2 <= product;
               default: rb  <= rb;
            endcase
            if (step != STEP_Z2) step <= step + 3'd1;
            else                 step <= step;
         end
         // Outputs only change when a new result is published.
         if ((state == ST_DONE) && !out_valid) begin
            out_valid <= 1'b1;
            x2        <= rx2;
            y2        <= ry2;
            z2        <= rz2;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_point_double_iter.sv
// Scoreboard bench for point_double_iter: small-field instances (a=-1 and a=+1)
// plus one default-parameter instance for the 2^255-19 field.
module tb_point_double_iter;
   localparam logic [255:0] P25519 = (256'd1 << 255) - 256'd19;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic         iv0, ir0, ov0, or0;
   logic [3:0]   x1_0, y1_0, z1_0, x2_0, y2_0, z2_0;
   logic         iv1, ir1, ov1, or1;
   logic [3:0]   x1_1, y1_1, z1_1, x2_1, y2_1, z2_1;
   logic         iv2, ir2, ov2, or2;
   logic [254:0] x1_2, y1_2, z1_2, x2_2, y2_2, z2_2;

   int n_tests = 0, n_fail = 0;
   int n_pushed = 0, n_results = 0, n_dropped = 0;

   typedef struct { int x; int y; int z; } exp_t;
   exp_t q[$];

   point_double_iter #(.W(4), .P(4'd13), .A_NEG(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
      .x1(x1_0), .y1(y1_0), .z1(z1_0), .out_valid(ov0), .out_ready(or0),
      .x2(x2_0), .y2(y2_0), .z2(z2_0));

   point_double_iter #(.W(4), .P(4'd13), .A_NEG(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .x1(x1_1), .y1(y1_1), .z1(z1_1), .out_valid(ov1), .out_ready(or1),
      .x2(x2_1), .y2(y2_1), .z2(z2_1));

   point_double_iter dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .x1(x1_2), .y1(y1_2), .z1(z1_2), .out_valid(ov2), .out_ready(or2),
      .x2(x2_2), .y2(y2_2), .z2(z2_2));

   function automatic int md(input int v, input int p);
      return ((v % p) + p) % p;
   endfunction

   // Reference: doubling formula evaluated directly in integer arithmetic mod p.
   function automatic void ref_dbl(input int x, input int y, input int z, input int p,
                                   input bit aneg, output int rx, output int ry, output int rz);
      int b, c, d, e, f, h, j;
      b  = md((x + y) * (x + y), p);
      c  = md(x * x, p);
      d  = md(y * y, p);
      e  = aneg ? md(-c, p) : c;
      f  = md(e + d, p);
      h  = md(z * z, p);
      j  = md(f - 2 * h, p);
      rx = md(md(b - c - d, p) * j, p);
      ry = md(f * md(e - d, p), p);
      rz = md(f * j, p);
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue tracker: every accepted input of dut0 produces one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && iv0 && ir0) begin
         ref_dbl(int'(x1_0), int'(y1_0), int'(z1_0), 13, 1'b1, e.x, e.y, e.z);
         q.push_back(e);
         n_pushed++;
      end
   end

   // Monitor: every completed output handshake of dut0 is checked in order.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ov0 && or0) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: got result (%0d,%0d,%0d), expected none", x2_0, y2_0, z2_0);
         end else begin
            e = q.pop_front();
            check("sb_x2", 256'(x2_0), 256'(e.x));
            check("sb_y2", 256'(y2_0), 256'(e.y));
            check("sb_z2", 256'(z2_0), 256'(e.z));
            n_results++;
         end
      end
   end

   task automatic issue(input int which, input logic [254:0] x, input logic [254:0] y,
                        input logic [254:0] z);
      @(posedge clk); #1;
      case (which)
         0: begin iv0 = 1'b1; x1_0 = x[3:0]; y1_0 = y[3:0]; z1_0 = z[3:0];
                  check("issue_ready0", 256'(ir0), 256'(1)); end
         1: begin iv1 = 1'b1; x1_1 = x[3:0]; y1_1 = y[3:0]; z1_1 = z[3:0];
                  check("issue_ready1", 256'(ir1), 256'(1)); end
         default: begin iv2 = 1'b1; x1_2 = x; y1_2 = y; z1_2 = z;
                  check("issue_ready2", 256'(ir2), 256'(1)); end
      endcase
      @(posedge clk); #1;
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
      x1_0 = ~x1_0; y1_0 = ~y1_0; z1_0 = ~z1_0;
      x1_1 = ~x1_1; y1_1 = ~y1_1; z1_1 = ~z1_1;
      x1_2 = ~x1_2; y1_2 = ~y1_2; z1_2 = ~z1_2;
   endtask

   task automatic wait_valid(input int which, input int bound, output int cyc);
      logic v;
      v   = 1'b0;
      cyc = 0;
      while (!v && cyc < bound) begin
         @(posedge clk); #1;
         cyc++;
         case (which)
            0:       v = ov0;
            1:       v = ov1;
            default: v = ov2;
         endcase
      end
      if (!v) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_dut%0d: out_valid low after %0d cycles, expected high", which, bound);
      end
   endtask

   initial begin
      int cyc, n, guard, ex, ey, ez;
      rst_n = 1'b0;
      {iv0, or0, iv1, or1, iv2, or2} = 6'b0;
      {x1_0, y1_0, z1_0, x1_1, y1_1, z1_1} = 24'd0;
      {x1_2, y1_2, z1_2} = {765{1'b0}};

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(ov0), 256'(0));
      check("rst_x2", 256'(x2_0), 256'(0));
      check("rst_yz2", 256'({y2_0, z2_0}), 256'(0));
      check("rst_out_valid_big", 256'(ov2), 256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 256'(ir0), 256'(1));

      // Known vector, latency, and a 20-cycle output stall.
      issue(0, 255'd2, 255'd3, 255'd1);
      wait_valid(0, 100, cyc);
      check("latency_w4", 256'(cyc), 256'(36));
      check("vec_x2", 256'(x2_0), 256'(10));
      check("vec_y2", 256'(y2_0), 256'(0));
      check("vec_z2", 256'(z2_0), 256'(2));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_out_valid", 256'(ov0), 256'(1));
         check("stall_in_ready", 256'(ir0), 256'(0));
         check("stall_result", 256'({x2_0, y2_0, z2_0}), 256'({4'd10, 4'd0, 4'd2}));
      end
      @(posedge clk); #1;
      or0 = 1'b1;
      @(posedge clk); #1;
      or0 = 1'b0;
      check("post_hs_out_valid", 256'(ov0), 256'(0));
      check("post_hs_in_ready", 256'(ir0), 256'(1));
      check("post_hs_retained", 256'({x2_0, y2_0, z2_0}), 256'({4'd10, 4'd0, 4'd2}));

      // Abort during the H multiplication, then recompute from scratch.
      issue(0, 255'd2, 255'd3, 255'd1);
      repeat (16) @(posedge clk);
      #1;
      rst_n = 1'b0;
      n_dropped += q.size();
      q.delete();
      #1;
      check("abort_out_valid", 256'(ov0), 256'(0));
      check("abort_outputs", 256'({x2_0, y2_0, z2_0}), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_in_ready", 256'(ir0), 256'(1));
      or0 = 1'b1;
      issue(0, 255'd2, 255'd3, 255'd1);
      wait_valid(0, 100, cyc);
      check("abort_latency", 256'(cyc), 256'(36));
      check("abort_result", 256'({x2_0, y2_0, z2_0}), 256'({4'd10, 4'd0, 4'd2}));
      @(posedge clk); #1;

      // Back-to-back random points with in_valid held high.
      n = 0;
      guard = 0;
      iv0 = 1'b1;
      x1_0 = 4'($urandom_range(0, 12));
      y1_0 = 4'($urandom_range(0, 12));
      z1_0 = 4'($urandom_range(0, 12));
      while (n < 100 && guard < 8000) begin
         guard++;
         if (ir0) begin
            @(posedge clk); #1;
            n++;
            x1_0 = 4'($urandom_range(0, 12));
            y1_0 = 4'($urandom_range(0, 12));
            z1_0 = 4'($urandom_range(0, 12));
            if (n == 100) iv0 = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      iv0 = 1'b0;
      check("b2b_accepted", 256'(n), 256'(100));
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("sb_pending", 256'(q.size()), 256'(0));
      check("sb_count", 256'(n_results), 256'(n_pushed - n_dropped));

      // a = +1 instance: fixed vector then a few random points.
      or1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int px, py, pz;
         px = (k == 0) ? 2 : $urandom_range(0, 12);
         py = (k == 0) ? 3 : $urandom_range(0, 12);
         pz = (k == 0) ? 1 : $urandom_range(0, 12);
         issue(1, 255'(px), 255'(py), 255'(pz));
         wait_valid(1, 100, cyc);
         ref_dbl(px, py, pz, 13, 1'b0, ex, ey, ez);
         check("apos_latency", 256'(cyc), 256'(36));
         check("apos_x2", 256'(x2_1), 256'(ex));
         check("apos_y2", 256'(y2_1), 256'(ey));
         check("apos_z2", 256'(z2_1), 256'(ez));
         @(posedge clk); #1;
      end

      // Default 2^255-19 field: neutral point doubles to itself (scaled).
      or2 = 1'b1;
      issue(2, 255'd0, 255'd1, 255'd1);
      wait_valid(2, 2000, cyc);
      check("big_latency", 256'(cyc), 256'(1793));
      check("big_x2", 256'(x2_2), 256'd0);
      check("big_y2", 256'(y2_2), P25519 - 256'd1);
      check("big_z2", 256'(z2_2), P25519 - 256'd1);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/point_double_iter.md
POINT_DOUBLE_ITER -- requirements
Module: point_double_iter

Interface
REQ-001 Parameter W, default 255; operand width in bits.
REQ-002 Parameter P, default 2^255-19 (W bits); field modulus, odd, P < 2^W.
REQ-003 Parameter A_NEG, default 1; 1 selects curve coefficient a=-1, 0 selects a=+1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  input point (x1,y1,z1) present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 x1, y1, z1  input  W each  projective input coordinates, each < P.
REQ-009 out_valid  output  1  result (x2,y2,z2) present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 x2, y2, z2  output  W each  projective doubled point, each in [0,P).

Function
REQ-012 Formula: B=(x1+y1)^2, C=x1^2, D=y1^2, E=a*C, F=E+D, H=z1^2, J=F-2H; x2=(B-C-D)*J, y2=F*(E-D), z2=F*J; all mod P.
REQ-013 All add/sub reduce to [0,P) by single conditional correction; E computed as P-C (C!=0) or 0 when A_NEG=1, as C when A_NEG=0.
REQ-014 One shared mod_mul instance; exactly 7 multiplications in fixed order B, C, D, H, x2, y2, z2.
REQ-015 FSM states IDLE, MUL, WAIT, DONE; IDLE->MUL on in_valid&&in_ready; MUL issues start one cycle ->WAIT; WAIT->MUL on mul done if step<6, ->DONE on done at step 6; DONE->IDLE on out_ready.
REQ-016 Step counter 3 bits, 0..6, cleared on accept, incremented on each mul done; never wraps.
REQ-017 Inputs captured into internal registers on accept; x1/y1/z1 may change afterwards without effect.
REQ-018 in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-019 mod_mul latency exactly W cycles start-to-done; each step costs W+1 cycles.
REQ-020 Latency: out_valid rises exactly 7*(W+1)+1 cycles after accepting edge (1793 at W=255).
REQ-021 x2/y2/z2 stable while out_valid=1 && out_ready=0; held indefinitely.
REQ-022 in_valid ignored outside IDLE; no queuing; next accept earliest the cycle after out_valid&&out_ready.
REQ-023 x2/y2/z2 retain last result after handshake until next result loads.

Reset
REQ-024 rst_n=0 forces IDLE, step=0, in_ready=1 after release, out_valid=0, x2=y2=z2=0, all intermediate registers 0.
REQ-025 Reset mid-operation aborts computation, discards partial results; mod_mul also returns to idle.

Structure
REQ-026 Shared package pd_pkg holds FSM state enum, step encoding, default W and P constants.
REQ-027 Sub-module mod_mul: bit-serial MSB-first interleaved modular multiplier, start/done pulse, same W,P parameters, same clk/rst_n.
REQ-028 Modular add/sub as combinational functions in pd_pkg; no further sub-modules.

Verification
REQ-029 W=4,P=13,A_NEG=1: input (2,3,1) -> (x2,y2,z2)=(10,0,2), out_valid 36 cycles after accept.
REQ-030 Defaults: input neutral (0,1,1) -> (0,P-1,P-1), latency 1793 cycles.
REQ-031 out_ready held 0 for 20 cycles after out_valid -> outputs unchanged, in_ready=0 throughout, then handshake -> IDLE next cycle.
REQ-032 rst_n pulled low at step 3 -> out_valid=0, outputs 0 immediately; fresh (2,3,1) after release (W=4,P=13) yields (10,0,2).
REQ-033 Back-to-back: in_valid held high, out_ready=1, 100 random points vs reference model -> all match, no extra or dropped results.
REQ-034 A_NEG=0, W=4, P=13, input (2,3,1) -> result equals model (E=C=4), latency 36 cycles.
